reg_writeback_arb: RTL and testbench

REG_WRITEBACK_ARB -- requirements
Module: reg_writeback_arb

---
 rtl/reg_writeback_arb_if.sv | 24 ++
 rtl/reg_writeback_arb.sv | 102 ++++++++++
 tb/tb_reg_writeback_arb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_arb_if.sv
// rtl/reg_writeback_arb_if.sv - ALU/IO result inputs and register-file write port of the writeback arbiter.
interface reg_writeback_arb_if;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_hold;
    logic        io_valid;
    logic        io_ready;
    logic [4:0]  io_waddr;
    logic [31:0] io_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_din;

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata, io_valid, io_waddr, io_wdata,
        output alu_hold, io_ready, rf_we, rf_waddr, rf_din
    );

    modport master (
        output alu_valid, alu_waddr, alu_wdata, io_valid, io_waddr, io_wdata,
        input  alu_hold, io_ready, rf_we, rf_waddr, rf_din
    );
endinterface

// File: rtl/reg_writeback_arb.sv
// rtl/reg_writeback_arb.sv - single-port register writeback arbiter: ALU priority, buffered IO results, anti-starvation drain.
// Optional macro WB_R0_DISCARD_EN suppresses every register-file write to address 0.
module reg_writeback_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    reg_writeback_arb_if.slave wb
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
`ifdef WB_R0_DISCARD_EN
    localparam logic R0_DISCARD = 1'b1;
`else
    localparam logic R0_DISCARD = 1'b0;
`endif

    logic [4:0]       buf_addr [DEPTH];
    logic [31:0]      buf_data [DEPTH];
    logic [DEPTH-1:0] buf_live;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic [CW-1:0]    starve_cnt;
    logic             ready_en;

    logic alu_win;
    logic drain;
    logic push;
    logic alu_we;
    logic drain_we;

    // ready_en keeps io_ready low through reset and rises on the first edge after release.
    assign wb.io_ready = ready_en && (count < DEPTH_C);
    assign wb.alu_hold = (starve_cnt == LIMIT_C);

    assign alu_win  = wb.alu_valid && !wb.alu_hold;
    assign drain    = !alu_win && (count != '0);
    assign push     = wb.io_valid && wb.io_ready;
    assign alu_we   = alu_win && !(R0_DISCARD && (wb.alu_waddr == 5'd0));
    assign drain_we = drain && buf_live[rd_ptr] && !(R0_DISCARD && (buf_addr[rd_ptr] == 5'd0));

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= wb.io_waddr;
            buf_data[wr_ptr] <= wb.io_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            buf_live   <= '0;
            starve_cnt <= '0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            // A winning ALU write supersedes any older buffered result for the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_win && (buf_addr[i] == wb.alu_waddr))
                    buf_live[i] <= 1'b0;
            end
            if (push) begin
                buf_live[wr_ptr] <= !(alu_win && (wb.io_waddr == wb.alu_waddr));
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (drain)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !drain)
                count <= count + 1'b1;
            else if (!push && drain)
                count <= count - 1'b1;
            if ((count == '0) || drain)
                starve_cnt <= '0;
            else if (alu_win && (starve_cnt != LIMIT_C))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Address and data only move on a real write so idle and dead-drain cycles hold them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.rf_we    <= 1'b0;
            wb.rf_waddr <= 5'd0;
            wb.rf_din   <= 32'd0;
        end else begin
            wb.rf_we <= alu_we || drain_we;
            if (alu_we) begin
                wb.rf_waddr <= wb.alu_waddr;
                wb.rf_din   <= wb.alu_wdata;
            end else if (drain_we) begin
                wb.rf_waddr <= buf_addr[rd_ptr];
                wb.rf_din   <= buf_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_arb.sv
// tb/tb_reg_writeback_arb.sv - vector table, corner sequences and random run against a queue-based model.
module tb_reg_writeback_arb;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_R0_DISCARD_EN
    localparam bit R0D = 1'b1;
`else
    localparam bit R0D = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] id;
        logic        e_ready;
        logic        e_hold;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_din;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_writeback_arb_if wb();

    reg_writeback_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wb   (wb.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    ent_t        m_q[$];
    int          m_starve;
    bit          m_rdy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_din;
    logic        s_ready;
    logic        s_hold;
    vec_t        tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_hold();
        return m_starve == LIMIT;
    endfunction

    function automatic bit m_ready();
        return m_rdy && (m_q.size() < DEPTH);
    endfunction

    function automatic bit writes(input logic [4:0] a);
        return !(R0D && a == 5'd0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_rdy    = 1'b0;
        m_we     = 1'b0;
        m_waddr  = 5'd0;
        m_din    = 32'd0;
    endtask

    task automatic model_edge(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic iv, input logic [4:0] ia, input logic [31:0] id);
        bit   win;
        bit   nonempty;
        bit   accept;
        ent_t e;
        win      = av && !m_hold();
        nonempty = m_q.size() != 0;
        accept   = iv && m_ready();
        m_we     = 1'b0;
        if (win) begin
            foreach (m_q[i]) if (m_q[i].addr == aa) m_q[i].live = 1'b0;
            if (writes(aa)) begin
                m_we = 1'b1; m_waddr = aa; m_din = ad;
            end
            m_starve = nonempty ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
        end else begin
            if (nonempty) begin
                e = m_q.pop_front();
                if (e.live && writes(e.addr)) begin
                    m_we = 1'b1; m_waddr = e.addr; m_din = e.data;
                end
            end
            m_starve = 0;
        end
        if (accept) m_q.push_back('{ia, id, !(win && ia == aa)});
        m_rdy = 1'b1;
    endtask

    // Entered and left on a falling edge; inputs apply to the following rising edge.
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic iv, input logic [4:0] ia, input logic [31:0] id);
        wb.alu_valid = av; wb.alu_waddr = aa; wb.alu_wdata = ad;
        wb.io_valid  = iv; wb.io_waddr  = ia; wb.io_wdata  = id;
        #1;
        s_ready = wb.io_ready;
        s_hold  = wb.alu_hold;
        chk("model io_ready", s_ready, m_ready());
        chk("model alu_hold", s_hold, m_hold());
        @(posedge clk);
        model_edge(av, aa, ad, iv, ia, id);
        #1;
        chk("model rf_we", wb.rf_we, m_we);
        chk("model rf_waddr", wb.rf_waddr, m_waddr);
        chk("model rf_din", wb.rf_din, m_din);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wb.alu_valid = 1'b0;
        wb.io_valid  = 1'b0;
        #1;
        chk("reset rf_we", wb.rf_we, 1'b0);
        chk("reset rf_waddr", wb.rf_waddr, 5'd0);
        chk("reset rf_din", wb.rf_din, 32'd0);
        chk("reset io_ready", wb.io_ready, 1'b0);
        chk("reset alu_hold", wb.alu_hold, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic iv, input logic [4:0] ia, input logic [31:0] id,
                                input logic er, input logic eh, input logic ew,
                                input logic [4:0] ea, input logic [31:0] ed);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.iv = iv; v.ia = ia; v.id = id;
        v.e_ready = er; v.e_hold = eh; v.e_we = ew; v.e_waddr = ea; v.e_din = ed;
        return v;
    endfunction

    initial begin
        wb.alu_valid = 1'b0; wb.alu_waddr = 5'd0; wb.alu_wdata = 32'd0;
        wb.io_valid  = 1'b0; wb.io_waddr  = 5'd0; wb.io_wdata  = 32'd0;
        model_reset();

        tbl[0]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     1, 0, 1, 5, 32'hDEADBEEF);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 5, 32'hDEADBEEF);
        tbl[3]  = mk(1, 1, 32'h100,      1, 7, 32'h11, 1, 0, 1, 1, 32'h100);
        tbl[4]  = mk(1, 2, 32'h200,      1, 8, 32'h22, 1, 0, 1, 2, 32'h200);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 1, 7, 32'h11);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0,     1, 0, 1, 8, 32'h22);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 8, 32'h22);
        tbl[8]  = mk(0, 0, 0,            1, 9, 32'hAA, 1, 0, 0, 8, 32'h22);
        tbl[9]  = mk(1, 9, 32'hBB,       0, 0, 0,     1, 0, 1, 9, 32'hBB);
        tbl[10] = mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 9, 32'hBB);
        tbl[11] = mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 9, 32'hBB);
        tbl[12] = mk(1, 3, 32'h33,       1, 3, 32'h44, 1, 0, 1, 3, 32'h33);
        tbl[13] = mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 3, 32'h33);
        if (R0D) tbl[14] = mk(1, 0, 32'h1, 0, 0, 0,   1, 0, 0, 3, 32'h33);
        else     tbl[14] = mk(1, 0, 32'h1, 0, 0, 0,   1, 0, 1, 0, 32'h1);

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].iv, tbl[i].ia, tbl[i].id);
            chk($sformatf("vec%0d io_ready", i), s_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d alu_hold", i), s_hold, tbl[i].e_hold);
            chk($sformatf("vec%0d rf_we", i), wb.rf_we, tbl[i].e_we);
            chk($sformatf("vec%0d rf_waddr", i), wb.rf_waddr, tbl[i].e_waddr);
            chk($sformatf("vec%0d rf_din", i), wb.rf_din, tbl[i].e_din);
        end

        // Starvation: one buffered entry, ALU busy for LIMIT cycles, then a forced drain.
        cycle(1'b1, 5'd11, 32'hB1, 1'b1, 5'd10, 32'hA0);
        for (int k = 1; k <= LIMIT; k++) begin
            cycle(1'b1, 5'd12, 32'(k), 1'b0, 5'd0, 32'd0);
            chk("starve hold low", s_hold, 1'b0);
            chk("starve alu write", wb.rf_waddr, 5'd12);
        end
        cycle(1'b1, 5'd10, 32'hCC, 1'b0, 5'd0, 32'd0);
        chk("starve hold high", s_hold, 1'b1);
        chk("starve drain we", wb.rf_we, 1'b1);
        chk("starve drain addr", wb.rf_waddr, 5'd10);
        chk("starve drain data", wb.rf_din, 32'hA0);
        idle();
        chk("starve hold one cycle", s_hold, 1'b0);
        chk("starve ignored alu", wb.rf_we, 1'b0);
        chk("starve held data", wb.rf_din, 32'hA0);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            end
        end

        // Reset with two live buffered entries: nothing may drain afterwards.
        idle(); idle(); idle();
        cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h55);
        cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h66);
        chk("full io_ready", wb.io_ready, 1'b0);
        do_reset();
        idle();
        chk("post-reset io_ready low", s_ready, 1'b0);
        chk("post-reset rf_we 0", wb.rf_we, 1'b0);
        idle();
        chk("post-reset io_ready high", s_ready, 1'b1);
        chk("post-reset rf_we 1", wb.rf_we, 1'b0);
        idle();
        chk("post-reset rf_we 2", wb.rf_we, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
